jtag_scan_master: RTL

//  Host-side JTAG initiator: drives TCK/TMS/TDI and samples TDO from target TAP + dr block.

---
 rtl/jtag_scan_master_if.sv | 16 +
 rtl/jtag_scan_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/jtag_scan_master_if.sv
// jtag_scan_master_if: command/response channel between a debug host and the JTAG scan master.
interface jtag_scan_master_if #(
    parameter int MAX_LEN = 8,
    parameter int LW = $clog2(MAX_LEN + 1)
);
    logic cmd_valid;
    logic cmd_ready;
    logic [1:0] cmd_op;
    logic [LW-1:0] cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic busy;
    modport master (output cmd_valid, cmd_op, cmd_len, cmd_data, input cmd_ready, rsp_valid, rsp_data, busy);
    modport slave (input cmd_valid, cmd_op, cmd_len, cmd_data, output cmd_ready, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: runs one TAP reset, IR scan or DR scan per command, starting and ending in Run-Test/Idle.
module jtag_scan_master #(
    parameter int MAX_LEN = 8,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic trst,
    jtag_scan_master_if.slave cmd,
    output logic tck,
    output logic tms,
    output logic tdi,
    input  logic tdo
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, DONE} state_t;
    state_t state, state_n;
    logic [DW-1:0] div, div_n;
    logic [2:0] step, step_n, hdr_last, ones;
    logic [LW-1:0] rem, rem_n, lenm1, lenm1_n, len_c;
    logic [1:0] op, op_n;
    logic [MAX_LEN-1:0] data, data_n, mask, mask_n, rsp, rsp_n;
    logic tck_n, tms_n, tdi_n, rsp_valid, rsp_valid_n;
    logic accept, active, half_end, rise, fall, last_pre;

    assign cmd.cmd_ready = state == IDLE;
    assign cmd.busy = state != IDLE;
    assign cmd.rsp_valid = rsp_valid;
    assign cmd.rsp_data = rsp;
    assign accept = state == IDLE && cmd.cmd_valid;
    assign active = state == PRE || state == SHIFT || state == POST;
    assign half_end = div == DW'(CLK_DIV - 1);
    assign rise = active && half_end && !tck;
    assign fall = active && half_end && tck;
    // TMS header: 'ones' leading 1s then 0s up to step hdr_last
    assign hdr_last = op == 2'b10 ? 3'd5 : op == 2'b01 ? 3'd3 : 3'd2;
    assign ones = op == 2'b10 ? 3'd5 : op == 2'b01 ? 3'd2 : 3'd1;
    assign last_pre = step == hdr_last;
    assign len_c = cmd.cmd_len == '0 ? LW'(1) : cmd.cmd_len > LW'(MAX_LEN) ? LW'(MAX_LEN) : cmd.cmd_len;

    always_ff @(posedge clk or negedge trst) begin
        if (!trst) begin
            state <= IDLE;
            div <= '0;
            step <= '0;
            rem <= '0;
            lenm1 <= '0;
            op <= '0;
            data <= '0;
            mask <= '0;
            rsp <= '0;
            tck <= 1'b0;
            tms <= 1'b1;
            tdi <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_n;
            div <= div_n;
            step <= step_n;
            rem <= rem_n;
            lenm1 <= lenm1_n;
            op <= op_n;
            data <= data_n;
            mask <= mask_n;
            rsp <= rsp_n;
            tck <= tck_n;
            tms <= tms_n;
            tdi <= tdi_n;
            rsp_valid <= rsp_valid_n;
        end
    end

    always_comb begin
        state_n = state == IDLE ? (accept ? (cmd.cmd_op == 2'b11 ? DONE : PRE) : IDLE)
                : state == DONE ? IDLE
                : !fall ? state
                : state == PRE ? (last_pre ? (op == 2'b10 ? DONE : SHIFT) : PRE)
                : state == SHIFT ? (rem == '0 ? POST : SHIFT)
                : state == POST ? (step == 3'd1 ? DONE : POST) : IDLE;
    end

    always_comb begin
        div_n = active ? (half_end ? '0 : div + 1'b1) : '0;
        tck_n = active && half_end ? !tck : tck;
        step_n = step;
        rem_n = rem;
        lenm1_n = lenm1;
        op_n = op;
        data_n = data;
        mask_n = mask;
        rsp_n = rsp;
        tms_n = tms;
        tdi_n = tdi;
        rsp_valid_n = state == DONE;
        if (accept) begin
            op_n = cmd.cmd_op;
            lenm1_n = len_c - LW'(1);
            data_n = cmd.cmd_data;
            rsp_n = '0;
            step_n = '0;
            tms_n = cmd.cmd_op == 2'b11 ? tms : 1'b1;
            tdi_n = 1'b0;
        end
        if (rise && state == SHIFT) rsp_n = rsp | (tdo ? mask : '0);
        if (fall && state == PRE && !last_pre) begin
            step_n = step + 3'd1;
            tms_n = step + 3'd1 < ones;
        end
        if (fall && state == PRE && last_pre && op != 2'b10) begin
            step_n = '0;
            rem_n = lenm1;
            mask_n = MAX_LEN'(1);
            tms_n = lenm1 == '0;
            tdi_n = data[0];
        end
        if (fall && state == SHIFT && rem != '0) begin
            rem_n = rem - LW'(1);
            data_n = data >> 1;
            mask_n = mask << 1;
            tdi_n = data_n[0];
            tms_n = rem == LW'(1);
        end
        if (fall && state == SHIFT && rem == '0) begin
            step_n = '0;
            tms_n = 1'b1;
            tdi_n = 1'b0;
        end
        if (fall && state == POST) begin
            step_n = step + 3'd1;
            tms_n = 1'b0;
        end
    end
endmodule
